// File: rtl/seven_seg_capture_pkg.sv
// Shared definitions for the multiplexed 7-segment capture path: glyph codes,
// digit-select polarity, FSM state encodings and the decoded-glyph record.
package seven_seg_capture_pkg;

  // Active-high segment patterns {g,f,e,d,c,b,a} for the 16 hex glyphs.
  localparam logic [6:0] GLYPH_0 = 7'h3F;
  localparam logic [6:0] GLYPH_1 = 7'h06;
  localparam logic [6:0] GLYPH_2 = 7'h5B;
  localparam logic [6:0] GLYPH_3 = 7'h4F;
  localparam logic [6:0] GLYPH_4 = 7'h66;
  localparam logic [6:0] GLYPH_5 = 7'h6D;
  localparam logic [6:0] GLYPH_6 = 7'h7D;
  localparam logic [6:0] GLYPH_7 = 7'h07;
  localparam logic [6:0] GLYPH_8 = 7'h7F;
  localparam logic [6:0] GLYPH_9 = 7'h6F;
  localparam logic [6:0] GLYPH_A = 7'h77;
  localparam logic [6:0] GLYPH_B = 7'h7C;
  localparam logic [6:0] GLYPH_C = 7'h39;
  localparam logic [6:0] GLYPH_D = 7'h5E;
  localparam logic [6:0] GLYPH_E = 7'h79;
  localparam logic [6:0] GLYPH_F = 7'h71;

  // Digit select carried in bit 7 of the drive word.
  localparam logic SEL_LSB = 1'b1;
  localparam logic SEL_MSB = 1'b0;

  // Byte re-assembly FSM states.
  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_LSB  = 1'b1;

  typedef struct packed {
    logic       valid;
    logic [3:0] nibble;
  } glyph_dec_t;

endpackage

// File: rtl/seven_seg_glyph_decode.sv
// Combinational decode of an active-high 7-segment pattern back to a hex nibble.
// Only the 16 hex glyphs are valid; blanks, dashes and anything else flag invalid.
module seven_seg_glyph_decode
  import seven_seg_capture_pkg::*;
(
  input  logic [6:0] pattern_i,
  output glyph_dec_t dec_o
);

  // Exact-match lookup; unmatched patterns report valid=0 with nibble 0.
  always_comb begin
    dec_o.valid  = 1'b1;
    dec_o.nibble = 4'h0;
    case (pattern_i)
      GLYPH_0: dec_o.nibble = 4'h0;
      GLYPH_1: dec_o.nibble = 4'h1;
      GLYPH_2: dec_o.nibble = 4'h2;
      GLYPH_3: dec_o.nibble = 4'h3;
      GLYPH_4: dec_o.nibble = 4'h4;
      GLYPH_5: dec_o.nibble = 4'h5;
      GLYPH_6: dec_o.nibble = 4'h6;
      GLYPH_7: dec_o.nibble = 4'h7;
      GLYPH_8: dec_o.nibble = 4'h8;
      GLYPH_9: dec_o.nibble = 4'h9;
      GLYPH_A: dec_o.nibble = 4'hA;
      GLYPH_B: dec_o.nibble = 4'hB;
      GLYPH_C: dec_o.nibble = 4'hC;
      GLYPH_D: dec_o.nibble = 4'hD;
      GLYPH_E: dec_o.nibble = 4'hE;
      GLYPH_F: dec_o.nibble = 4'hF;
      default: dec_o.valid  = 1'b0;
    endcase
  end

endmodule

// File: rtl/seven_seg_capture.sv
// Receive side of the two-digit multiplexed 7-segment bus: synchronises the drive
// word, filters glitches, decodes each stable frame and re-assembles the byte.
module seven_seg_capture
  import seven_seg_capture_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES  = 4,
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] seg_in,
  output logic [7:0] dout,
  output logic       dout_valid,
  output logic       dout_err,
  output logic       stale
);

  localparam int unsigned CntW = $clog2(STABLE_CYCLES + 1);
  localparam int unsigned TmoW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CntW-1:0] CntMax  = CntW'(STABLE_CYCLES);
  localparam logic [TmoW-1:0] TmoMax  = TmoW'(TIMEOUT_CYCLES);
  localparam logic [TmoW-1:0] TmoLast = TmoW'(TIMEOUT_CYCLES - 1);

  logic [7:0]      sync1_q, sync2_q;
  logic [7:0]      word_q;       // previous synced sample; the word being qualified
  logic [7:0]      last_q, last_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [TmoW-1:0] tmo_q, tmo_d;
  logic [0:0]      state_q, state_d;
  logic [3:0]      lsb_q, lsb_d;
  logic [7:0]      dout_q, dout_d;
  logic            valid_q, valid_d;
  logic            err_q, err_d;
  logic            stale_q, stale_d;
  logic            accept;
  glyph_dec_t      dec;

  assign dout       = dout_q;
  assign dout_valid = valid_q;
  assign dout_err   = err_q;
  assign stale      = stale_q;

  seven_seg_glyph_decode u_decode (
    .pattern_i (~word_q[6:0]),
    .dec_o     (dec)
  );

  // Stability filter: count consecutive identical samples, accept once per new word.
  always_comb begin
    cnt_d = cnt_q;
    if (sync2_q != word_q) begin
      cnt_d = CntW'(1);
    end else if (cnt_q != CntMax) begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  assign accept = (cnt_q == CntMax) && (word_q != last_q);

  // Re-assembly FSM and timeout; an accept takes priority over timeout expiry.
  always_comb begin
    state_d = state_q;
    lsb_d   = lsb_q;
    dout_d  = dout_q;
    valid_d = 1'b0;
    err_d   = 1'b0;
    stale_d = stale_q;
    last_d  = last_q;
    tmo_d   = tmo_q;
    if (accept) begin
      last_d = word_q;
      tmo_d  = '0;
      if (!dec.valid) begin
        err_d   = 1'b1;
        lsb_d   = 4'h0;
        state_d = S_IDLE;
      end else if (word_q[7] == SEL_LSB) begin
        lsb_d   = dec.nibble;
        state_d = S_LSB;
      end else if (state_q == S_LSB) begin
        dout_d  = {dec.nibble, lsb_q};
        valid_d = 1'b1;
        stale_d = 1'b0;
        state_d = S_IDLE;
      end
    end else if (tmo_q != TmoMax) begin
      tmo_d = tmo_q + TmoW'(1);
      if (tmo_q == TmoLast) begin
        stale_d = 1'b1;
        state_d = S_IDLE;
      end
    end
  end

  // State registers; reset returns everything to idle with stale asserted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 8'h00;
      sync2_q <= 8'h00;
      word_q  <= 8'h00;
      last_q  <= 8'h00;
      cnt_q   <= '0;
      tmo_q   <= '0;
      state_q <= S_IDLE;
      lsb_q   <= 4'h0;
      dout_q  <= 8'h00;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      stale_q <= 1'b1;
    end else begin
      sync1_q <= seg_in;
      sync2_q <= sync1_q;
      word_q  <= sync2_q;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      tmo_q   <= tmo_d;
      state_q <= state_d;
      lsb_q   <= lsb_d;
      dout_q  <= dout_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      stale_q <= stale_d;
    end
  end

endmodule
